// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions for the P7 core: register numbers, field positions,
// exception codes and the fixed handler/PRId values.
package cp0_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'd31;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE_DEF   = 32'h2023_0701;

  // EPC and mtc0-to-EPC always hold word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_unit_int_arbiter.sv
// Combinational interrupt/exception arbitration; interrupts win over
// synchronous exceptions and EXL masks both.
module cp0_int_arbiter #(
  parameter logic [4:0] NO_EXC = 5'd31
) (
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code,
  output logic       int_req,
  output logic       exc_req,
  output logic       req
);

  assign int_req = ie & ~exl & (|(hw_int & im));
  assign exc_req = (exc_code != NO_EXC) & ~exl;
  assign req     = int_req | exc_req;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId, mtc0/mfc0/eret service and
// the pipeline-wide exception request.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [31:0] PRID_VALUE   = PRID_VALUE_DEF,
  parameter logic [4:0]  NO_EXC       = EXC_NONE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exc_code_m,
  input  logic        bd_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  logic [5:0]  im_reg, im_next;
  logic        exl_reg, exl_next;
  logic        ie_reg, ie_next;
  logic        bd_reg, bd_next;
  logic [5:0]  ip_reg, ip_next;
  logic [4:0]  exc_code_reg, exc_code_next;
  logic [31:0] epc_reg, epc_next;
  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  cp0_int_arbiter #(
    .NO_EXC(NO_EXC)
  ) u_arbiter (
    .ie      (ie_reg),
    .exl     (exl_reg),
    .im      (im_reg),
    .hw_int  (hw_int),
    .exc_code(exc_code_m),
    .int_req (int_req),
    .exc_req (exc_req),
    .req     (req)
  );

  always_comb begin
    im_next       = im_reg;
    exl_next      = exl_reg;
    ie_next       = ie_reg;
    bd_next       = bd_reg;
    exc_code_next = exc_code_reg;
    epc_next      = epc_reg;
    ip_next       = hw_int;
    if (req) begin
      // Flushed instruction: any mtc0/eret riding along is dropped.
      exl_next      = 1'b1;
      exc_code_next = int_req ? EXC_INT : exc_code_m;
      bd_next       = bd_m;
      epc_next      = bd_m ? (word_align(pc_m) - 32'd4) : word_align(pc_m);
    end else begin
      if (eret_m) begin
        exl_next = 1'b0;
      end
      // Evaluated after eret so an mtc0 to SR decides EXL when both occur.
      if (cp0_we) begin
        case (cp0_addr)
          REG_SR: begin
            im_next  = cp0_wdata[SR_IM_HI:SR_IM_LO];
            exl_next = cp0_wdata[SR_EXL];
            ie_next  = cp0_wdata[SR_IE];
          end
          REG_EPC: epc_next = word_align(cp0_wdata);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      im_reg       <= im_next;
      exl_reg      <= exl_next;
      ie_reg       <= ie_next;
      bd_reg       <= bd_next;
      ip_reg       <= ip_next;
      exc_code_reg <= exc_code_next;
      epc_reg      <= epc_next;
    end
  end

  always_comb begin
    sr_word                         = '0;
    sr_word[SR_IM_HI:SR_IM_LO]      = im_reg;
    sr_word[SR_EXL]                 = exl_reg;
    sr_word[SR_IE]                  = ie_reg;
    cause_word                      = '0;
    cause_word[CAUSE_BD]            = bd_reg;
    cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_reg;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_reg;
  end

  always_comb begin
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_word;
      REG_CAUSE: cp0_rdata = cause_word;
      REG_EPC:   cp0_rdata = epc_reg;
      REG_PRID:  cp0_rdata = PRID_VALUE;
      default:   cp0_rdata = '0;
    endcase
  end

  assign epc_out    = epc_reg;
  assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed plus randomized check of cp0_unit against a register-level model.
module tb_cp0_unit;
  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h2023_0701;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_m = '0;
  logic [4:0]  exc_code_m = 5'd31;
  logic        bd_m = 1'b0;
  logic [5:0]  hw_int = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] cp0_wdata = '0;
  logic        eret_m = 1'b0;
  logic [31:0] cp0_rdata, epc_out, handler_pc;
  logic        req;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state as whole architectural register words.
  logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .exc_code_m(exc_code_m), .bd_m(bd_m),
    .hw_int(hw_int), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .eret_m(eret_m), .cp0_rdata(cp0_rdata), .epc_out(epc_out), .req(req),
    .handler_pc(handler_pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_int();
    return m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic bit model_req();
    return model_int() || (exc_code_m != 5'd31 && !m_sr[1]);
  endfunction

  // One M-stage cycle: apply inputs, check outputs, advance the model.
  task automatic step(input bit rst, input logic [31:0] pc, input logic [4:0] code,
                      input bit bd, input logic [5:0] hw, input bit we,
                      input logic [4:0] addr, input logic [31:0] wd, input bit eret);
    bit r, ir;
    @(posedge clk);
    #1;
    reset = rst; pc_m = pc; exc_code_m = code; bd_m = bd; hw_int = hw;
    cp0_we = we; cp0_addr = addr; cp0_wdata = wd; eret_m = eret;
    #1;
    r  = model_req();
    ir = model_int();
    check_val("req", {31'd0, req}, {31'd0, r});
    check_val("rdata", cp0_rdata, model_read(addr));
    check_val("epc_out", epc_out, m_epc);
    check_val("handler_pc", handler_pc, HANDLER);
    if (rst) begin
      m_sr = '0; m_cause = '0; m_epc = '0;
    end else begin
      m_cause[15:10] = hw;
      if (r) begin
        m_sr[1]       = 1'b1;
        m_cause[6:2]  = ir ? 5'd0 : code;
        m_cause[31]   = bd;
        m_epc         = (pc & 32'hFFFF_FFFC) - (bd ? 32'd4 : 32'd0);
      end else begin
        if (eret) m_sr[1] = 1'b0;
        if (we && addr == 5'd12) m_sr = wd & 32'h0000_FC03;
        if (we && addr == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
      end
    end
  endtask

  task automatic rd(input logic [4:0] addr, input logic [5:0] hw);
    step(0, 32'h0, 5'd31, 0, hw, 0, addr, 32'h0, 0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
    step(0, 32'h0, 5'd31, 0, 6'd0, 1, addr, wd, 0);
  endtask

  initial begin
    logic [4:0] codes [6];
    codes[0] = 5'd0; codes[1] = 5'd4; codes[2] = 5'd5;
    codes[3] = 5'd10; codes[4] = 5'd12; codes[5] = 5'd31;
    repeat (2) @(posedge clk);
    step(1, 32'h0, 5'd31, 0, 6'd0, 0, 5'd12, 32'h0, 0);
    rd(5'd12, 0); check_val("rst_sr", cp0_rdata, 32'h0);
    rd(5'd13, 0); check_val("rst_cause", cp0_rdata, 32'h0);
    rd(5'd14, 0); check_val("rst_epc", cp0_rdata, 32'h0);
    rd(5'd15, 0); check_val("prid", cp0_rdata, PRID);
    check_val("rst_req", {31'd0, req}, 32'd0);

    // Interrupt on IM[10] with IE.
    wr(5'd12, 32'h0000_0401);
    step(0, 32'h3010, 5'd31, 0, 6'b000001, 0, 5'd12, 0, 0);
    check_val("int_req", {31'd0, req}, 32'd1);
    rd(5'd14, 6'b000001); check_val("int_epc", cp0_rdata, 32'h3010);
    check_val("int_req_masked", {31'd0, req}, 32'd0);
    rd(5'd13, 6'b000001); check_val("int_exccode", {27'd0, cp0_rdata[6:2]}, 32'd0);
    rd(5'd12, 0); check_val("int_exl", cp0_rdata, 32'h0000_0403);

    // Overflow in delay slot with IE=0.
    wr(5'd12, 32'h0);
    step(0, 32'h3024, 5'd12, 1, 6'd0, 0, 5'd14, 0, 0);
    check_val("ov_req", {31'd0, req}, 32'd1);
    rd(5'd14, 0); check_val("ov_epc", cp0_rdata, 32'h3020);
    rd(5'd13, 0); check_val("ov_cause", cp0_rdata, 32'h8000_0030);
    rd(5'd12, 0); check_val("ov_sr", cp0_rdata, 32'h0000_0002);

    // Interrupt beats AdEL.
    wr(5'd12, 32'h0000_0401);
    step(0, 32'h3040, 5'd4, 0, 6'b000001, 0, 5'd13, 0, 0);
    rd(5'd13, 6'b000001); check_val("prio_exccode", {27'd0, cp0_rdata[6:2]}, 32'd0);
    rd(5'd14, 6'b000001); check_val("prio_epc", cp0_rdata, 32'h3040);

    // eret with interrupt still pending.
    step(0, 32'h0, 5'd31, 0, 6'b000001, 0, 5'd12, 0, 1);
    check_val("eret_req0", {31'd0, req}, 32'd0);
    rd(5'd12, 6'b000001);
    check_val("eret_req1", {31'd0, req}, 32'd1);
    check_val("eret_sr", cp0_rdata, 32'h0000_0401);

    // mtc0 EPC suppressed by req, then honoured.
    wr(5'd12, 32'h0000_0401);
    step(0, 32'h5000, 5'd31, 0, 6'b000001, 1, 5'd14, 32'h0000_3003, 0);
    rd(5'd14, 0); check_val("mtc0_suppr", cp0_rdata, 32'h5000);
    wr(5'd12, 32'h0);
    wr(5'd14, 32'h0000_3003);
    rd(5'd14, 0); check_val("mtc0_epc", cp0_rdata, 32'h3000);

    // Reset while in handler.
    wr(5'd12, 32'h0000_0403);
    step(1, 32'h0, 5'd31, 0, 6'b000001, 0, 5'd12, 0, 0);
    rd(5'd12, 6'b000001); check_val("mid_rst_sr", cp0_rdata, 32'h0);
    check_val("mid_rst_req", {31'd0, req}, 32'd0);
    rd(5'd14, 0); check_val("mid_rst_epc", cp0_rdata, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  a, c;
      logic [5:0]  h;
      logic [31:0] w;
      bit          we, er, rs, bdv;
      a   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      c   = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 4)] : 5'd31;
      h   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      w   = $urandom;
      if ($urandom_range(0, 1) == 0) w[1] = 1'b0;
      we  = ($urandom_range(0, 3) == 0);
      er  = ($urandom_range(0, 5) == 0);
      rs  = ($urandom_range(0, 199) == 0);
      bdv = $urandom_range(0, 1) == 1;
      step(rs, $urandom, c, bdv, h, we, a, w, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
